// File: rtl/comparator_mux.sv
// comparator_mux: registered magnitude comparator for two WIDTH-bit operands.
// The relation is resolved by an MSB-first cascade of 2:1 mux stages. Each
// stage either forwards the decision made by the more-significant bits or
// resolves it from its own bit pair. The result is held in three one-hot
// flags (eq/lt/gt) that are registered one clock after the operands are sampled.
// SIGNED=1 selects a two's-complement compare by flipping the sense of the
// sign-bit stage only.

module comparator_mux #(
    parameter int WIDTH  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Cascade state carried from stage to stage. It holds whether the
    // relation is already decided and, if so, whether it is "greater".
    logic decided;
    logic rel_gt;
    logic own_gt;
    logic stage_diff;

    // Next-state values of the flags, taken from the end of the cascade.
    logic eq_next;
    logic lt_next;
    logic gt_next;

    // Mux cascade, walked from the MSB down to bit 0. Once a stage has
    // decided, every later stage forwards that decision unchanged.
    always_comb begin
        decided    = 1'b0;
        rel_gt     = 1'b0;
        own_gt     = 1'b0;
        stage_diff = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            stage_diff = a[i] ^ b[i];
            // On the sign bit of a signed compare, a set bit means "more
            // negative", so the stage's own sense of "greater" is inverted.
            if ((SIGNED != 0) && (i == WIDTH - 1)) begin
                own_gt = b[i];
            end else begin
                own_gt = a[i];
            end
            if (!decided && stage_diff) begin
                decided = 1'b1;
                rel_gt  = own_gt;
            end
        end
    end

    // Map the end-of-cascade state onto the one-hot flag encoding.
    always_comb begin
        eq_next = ~decided;
        lt_next = decided & ~rel_gt;
        gt_next = decided & rel_gt;
    end

    // Output flags. Reset clears them immediately, and a new result is
    // loaded on every rising edge after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq <= 1'b0;
            lt <= 1'b0;
            gt <= 1'b0;
        end else begin
            eq <= eq_next;
            lt <= lt_next;
            gt <= gt_next;
        end
    end

endmodule

// File: tb/tb_comparator_mux.sv
// tb_comparator_mux: directed self-checking bench for comparator_mux.
// It runs three instances: a default 1-bit unsigned comparator, an 8-bit
// unsigned comparator and an 8-bit signed comparator. The two 8-bit
// instances share their operands.

module tb_comparator_mux;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       eq1, lt1, gt1;
    logic       eq8u, lt8u, gt8u;
    logic       eq8s, lt8s, gt8s;

    int checks   = 0;
    int failures = 0;

    comparator_mux u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .eq(eq1), .lt(lt1), .gt(gt1)
    );

    comparator_mux #(.WIDTH(8), .SIGNED(0)) u_dut8u (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .eq(eq8u), .lt(lt8u), .gt(gt8u)
    );

    comparator_mux #(.WIDTH(8), .SIGNED(1)) u_dut8s (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .eq(eq8s), .lt(lt8s), .gt(gt8s)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog that stops a run which never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Outputs must be cleared while rst is held from time zero
        checks++;
        if ({eq1, lt1, gt1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_init_1bit: got=%b exp=000", {eq1, lt1, gt1});
        end
        checks++;
        if ({eq8u, lt8u, gt8u} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_init_8u: got=%b exp=000", {eq8u, lt8u, gt8u});
        end
        step();
        step();
        checks++;
        if ({eq8s, lt8s, gt8s} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_hold_8s: got=%b exp=000", {eq8s, lt8s, gt8s});
        end

        // Release reset and produce gt=1 on the 1-bit instance
        @(negedge clk);
        rst = 1'b0;
        a1  = 1'b1;
        b1  = 1'b0;
        step();
        checks++;
        if ({eq1, lt1, gt1} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_pre_gt: got=%b exp=001", {eq1, lt1, gt1});
        end

        // Assert reset in mid-cycle: flags must drop with no clock edge
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({eq1, lt1, gt1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_async_clear: got=%b exp=000", {eq1, lt1, gt1});
        end

        // Change the inputs while in reset; the flags must still be held at zero
        a8 = 8'h80;
        b8 = 8'h7F;
        step();
        checks++;
        if ({eq1, lt1, gt1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_held_edge: got=%b exp=000", {eq1, lt1, gt1});
        end

        // Deassert in mid-cycle: no change until the next rising edge
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({eq1, lt1, gt1} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_release_noedge: got=%b exp=000", {eq1, lt1, gt1});
        end
        step();
        checks++;
        if ({eq1, lt1, gt1} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_first_result: got=%b exp=001", {eq1, lt1, gt1});
        end
        checks++;
        if ({eq8u, lt8u, gt8u} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL reset_first_8u: got=%b exp=001", {eq8u, lt8u, gt8u});
        end
        checks++;
        if ({eq8s, lt8s, gt8s} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL reset_first_8s: got=%b exp=010", {eq8s, lt8s, gt8s});
        end
    endtask

    task automatic test_exhaustive_1bit();
        logic [1:0] pairs [4];
        logic [2:0] exp   [4];
        pairs = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp   = '{3'b100, 3'b010, 3'b001, 3'b100};
        for (int i = 0; i < 4; i++) begin
            a1 = pairs[i][1];
            b1 = pairs[i][0];
            step();
            checks++;
            if ({eq1, lt1, gt1} !== exp[i]) begin
                failures++;
                $display("[TB] FAIL exh1_a%0d_b%0d: got=%b exp=%b",
                         pairs[i][1], pairs[i][0], {eq1, lt1, gt1}, exp[i]);
            end
        end
    endtask

    task automatic test_unsigned_8();
        logic [7:0] va  [4];
        logic [7:0] vb  [4];
        logic [2:0] exp [4];
        va  = '{8'h80, 8'h3C, 8'h00, 8'hA5};
        vb  = '{8'h7F, 8'h3C, 8'hFF, 8'hA4};
        exp = '{3'b001, 3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 4; i++) begin
            a8 = va[i];
            b8 = vb[i];
            step();
            checks++;
            if ({eq8u, lt8u, gt8u} !== exp[i]) begin
                failures++;
                $display("[TB] FAIL uns8_%h_%h: got=%b exp=%b",
                         va[i], vb[i], {eq8u, lt8u, gt8u}, exp[i]);
            end
        end
    endtask

    task automatic test_signed_8();
        logic [7:0] va  [5];
        logic [7:0] vb  [5];
        logic [2:0] exp [5];
        va  = '{8'h80, 8'hFF, 8'h01, 8'hFE, 8'h55};
        vb  = '{8'h7F, 8'h00, 8'hFF, 8'hFF, 8'h55};
        exp = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 5; i++) begin
            a8 = va[i];
            b8 = vb[i];
            step();
            checks++;
            if ({eq8s, lt8s, gt8s} !== exp[i]) begin
                failures++;
                $display("[TB] FAIL sgn8_%h_%h: got=%b exp=%b",
                         va[i], vb[i], {eq8s, lt8s, gt8s}, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y;
        logic       p, q;
        logic [2:0] exp_u, exp_s, exp_1;
        for (int i = 0; i < 16; i++) begin
            x = 8'($urandom_range(0, 255));
            y = (i % 4 == 0) ? x : 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            a8 = x;
            b8 = y;
            a1 = p;
            b1 = q;
            exp_u = (x == y) ? 3'b100 : ((x < y) ? 3'b010 : 3'b001);
            exp_s = (x == y) ? 3'b100 :
                    (($signed(x) < $signed(y)) ? 3'b010 : 3'b001);
            exp_1 = (p == q) ? 3'b100 : ((p < q) ? 3'b010 : 3'b001);
            step();
            checks++;
            if ({eq8u, lt8u, gt8u} !== exp_u) begin
                failures++;
                $display("[TB] FAIL b2b_uns_%0d (%h,%h): got=%b exp=%b",
                         i, x, y, {eq8u, lt8u, gt8u}, exp_u);
            end
            checks++;
            if ({eq8s, lt8s, gt8s} !== exp_s) begin
                failures++;
                $display("[TB] FAIL b2b_sgn_%0d (%h,%h): got=%b exp=%b",
                         i, x, y, {eq8s, lt8s, gt8s}, exp_s);
            end
            checks++;
            if ({eq1, lt1, gt1} !== exp_1) begin
                failures++;
                $display("[TB] FAIL b2b_1bit_%0d (%b,%b): got=%b exp=%b",
                         i, p, q, {eq1, lt1, gt1}, exp_1);
            end
            checks++;
            if ($countones({eq8s, lt8s, gt8s}) != 1) begin
                failures++;
                $display("[TB] FAIL b2b_onehot_%0d: got=%b exp=one-hot",
                         i, {eq8s, lt8s, gt8s});
            end
        end
    endtask

    task automatic test_latency();
        a8 = 8'h10;
        b8 = 8'h20;
        step();
        checks++;
        if ({eq8u, lt8u, gt8u} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL lat_first: got=%b exp=010", {eq8u, lt8u, gt8u});
        end
        // Inputs change just after the edge; flags must hold until the next edge
        a8 = 8'h20;
        b8 = 8'h10;
        #6;
        checks++;
        if ({eq8u, lt8u, gt8u} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL lat_hold: got=%b exp=010", {eq8u, lt8u, gt8u});
        end
        step();
        checks++;
        if ({eq8u, lt8u, gt8u} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL lat_update: got=%b exp=001", {eq8u, lt8u, gt8u});
        end
    endtask

    // Main sequence
    initial begin
        rst = 1'b1;
        a1  = 1'b0;
        b1  = 1'b0;
        a8  = 8'h00;
        b8  = 8'h00;
        #1;
        test_reset();
        test_exhaustive_1bit();
        test_unsigned_8();
        test_signed_8();
        test_back_to_back();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
